// File: rtl/mem_pkg.sv
// Shared types and constants for param_memory and its read pipeline.
package mem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam logic READ         = 1'b1;
    localparam logic WRITE        = 1'b0;
    localparam int   MAX_READ_LAT = 4;

endpackage

// File: rtl/mem_read_pipe.sv
// Valid/data shift pipeline for read responses; only the valid bits are reset,
// and each data stage loads only when a valid word arrives, so the last stage holds.
module mem_read_pipe #(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [READ_LAT-1:0] vld;
    logic [DATA_W-1:0]   dat [READ_LAT];

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < READ_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (in_valid) begin
            dat[0] <= in_data;
        end
        for (int i = 1; i < READ_LAT; i++) begin
            if (vld[i-1]) begin
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[READ_LAT-1];
    assign out_data  = dat[READ_LAT-1];

endmodule

// File: rtl/param_memory.sv
// DATA_W x 2**ADDR_W RAM with valid/ready requests, pipelined reads and a zeroing sweep after reset.
// Define MEM_BUS_OUT_EN to add the tri-state uniBus mirror of rsp_rdata.
//
// state    | meaning
// ST_INIT  | clearing mem[ptr] each cycle, requests refused
// ST_READY | sweep done, one request accepted per cycle
module param_memory
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
`ifdef MEM_BUS_OUT_EN
    ,
    inout  wire  [DATA_W-1:0] uniBus
`endif
);

    if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_lat_check
        $error("param_memory: READ_LAT must be within 1..MAX_READ_LAT");
    end

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    mem_state_e        state;
    logic [ADDR_W-1:0] ptr;
    logic              rsp_seen;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              accept;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    assign accept = req_valid && req_ready;

    always_comb begin
        we    = 1'b0;
        waddr = req_addr;
        wdata = req_wdata;
        if (!RST) begin
            if (state == ST_INIT) begin
                we    = 1'b1;
                waddr = ptr;
                wdata = '0;
            end else if (accept && req_rw == WRITE) begin
                we = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            ptr       <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            rsp_seen  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (ptr == PTR_LAST) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_READY: ;
                default: state <= ST_INIT;
            endcase
            if (pipe_valid) begin
                rsp_seen <= 1'b1;
            end
        end
    end

    mem_read_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_read_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (accept && req_rw == READ && !RST),
        .in_data   (mem[req_addr]),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // Pipeline data is not reset; mask it to zero until the first response after reset.
    assign rsp_valid = pipe_valid;
    assign rsp_rdata = (pipe_valid || rsp_seen) ? pipe_data : '0;

`ifdef MEM_BUS_OUT_EN
    assign uniBus = rsp_valid ? rsp_rdata : {DATA_W{1'bz}};
`endif

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench for param_memory: three instances (READ_LAT 1, 3, 4) share stimulus
// and are compared every cycle against an edge-history reference model.
module tb_param_memory;
    import mem_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;
    localparam int MAXE  = 4096;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_rw = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;

    logic [NI-1:0]         rdy;
    logic [NI-1:0]         idn;
    logic [NI-1:0]         rv;
    logic [NI-1:0][DW-1:0] rd;

`ifdef MEM_BUS_OUT_EN
    wire [DW-1:0] bus0;
    wire [DW-1:0] bus1;
    wire [DW-1:0] bus2;
`endif

    param_memory #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy[0]), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_rdata(rd[0]),
        .init_done(idn[0])
`ifdef MEM_BUS_OUT_EN
        , .uniBus(bus0)
`endif
    );

    param_memory #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(3)) u_lat3 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy[1]), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_rdata(rd[1]),
        .init_done(idn[1])
`ifdef MEM_BUS_OUT_EN
        , .uniBus(bus1)
`endif
    );

    param_memory #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(4)) u_lat4 (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy[2]), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_rdata(rd[2]),
        .init_done(idn[2])
`ifdef MEM_BUS_OUT_EN
        , .uniBus(bus2)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: memory contents, readiness, and a per-edge history of accepted reads/resets.
    int            lats [NI];
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_left;
    int            edge_n;
    bit            acc_h [MAXE];
    bit            rst_h [MAXE];
    logic [DW-1:0] dat_h [MAXE];
    logic [DW-1:0] held [NI];

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step();
        if (edge_n >= MAXE - 1) begin
            $display("FAIL edge_budget: got %0d edges expected below %0d", edge_n, MAXE - 1);
            $fatal(1, "edge budget exhausted");
        end
        edge_n++;
        acc_h[edge_n] = 1'b0;
        rst_h[edge_n] = RST;
        if (RST) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else if (req_valid) begin
            if (req_rw == READ) begin
                acc_h[edge_n] = 1'b1;
                dat_h[edge_n] = m_mem[req_addr];
            end else begin
                m_mem[req_addr] = req_wdata;
            end
        end
    endtask

    task automatic model_check();
        int            a;
        logic          ev;
        logic [DW-1:0] eb;
        logic [DW-1:0] busv;
        for (int l = 0; l < NI; l++) begin
            a  = edge_n - lats[l] + 1;
            ev = 1'b0;
            if (a >= 1 && acc_h[a]) begin
                ev = 1'b1;
                for (int e = a + 1; e <= edge_n; e++) if (rst_h[e]) ev = 1'b0;
            end
            if (rst_h[edge_n]) held[l] = '0;
            if (ev) held[l] = dat_h[a];
            chk($sformatf("ready_lat%0d", lats[l]), 64'(rdy[l]), 64'(m_ready));
            chk($sformatf("init_done_lat%0d", lats[l]), 64'(idn[l]), 64'(m_ready));
            chk($sformatf("rsp_valid_lat%0d", lats[l]), 64'(rv[l]), 64'(ev));
            chk($sformatf("rsp_rdata_lat%0d", lats[l]), 64'(rd[l]), 64'(held[l]));
`ifdef MEM_BUS_OUT_EN
            eb   = ev ? held[l] : {DW{1'bz}};
            busv = (l == 0) ? bus0 : (l == 1) ? bus1 : bus2;
            chk($sformatf("uniBus_lat%0d", lats[l]), {56'h0, busv}, {56'h0, eb});
`else
            eb   = '0;
            busv = '0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        model_check();
    endtask

    task automatic do_reset(output int n);
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        n = 0;
        while (!idn[0] && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_rw    = rw;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        int n;
        int first [NI];
        lats[0] = 1; lats[1] = 3; lats[2] = 4;
        edge_n = 0;
        m_ready = 1'b0;
        m_left = DEPTH;
        for (int l = 0; l < NI; l++) held[l] = '0;

        tbl[0]  = '{WRITE, 4'd3,  8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{READ,  4'd3,  8'h00, 1'b1, 8'hA5};
        tbl[2]  = '{WRITE, 4'd0,  8'h10, 1'b0, 8'h00};
        tbl[3]  = '{WRITE, 4'd1,  8'h20, 1'b0, 8'h00};
        tbl[4]  = '{WRITE, 4'd2,  8'h30, 1'b0, 8'h00};
        tbl[5]  = '{READ,  4'd0,  8'h00, 1'b1, 8'h10};
        tbl[6]  = '{READ,  4'd1,  8'h00, 1'b1, 8'h20};
        tbl[7]  = '{READ,  4'd2,  8'h00, 1'b1, 8'h30};
        tbl[8]  = '{WRITE, 4'd15, 8'h5A, 1'b0, 8'h00};
        tbl[9]  = '{READ,  4'd15, 8'h00, 1'b1, 8'h5A};
        tbl[10] = '{READ,  4'd3,  8'h00, 1'b1, 8'hA5};

        @(negedge CLK);

        // Reset and sweep length, then every word reads back as zero.
        do_reset(n);
        chk("init_cycles", 64'(n), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, READ, AW'(i), '0);
            tick();
            chk($sformatf("zero_valid_a%0d", i), 64'(rv[0]), 64'd1);
            chk($sformatf("zero_data_a%0d", i), 64'(rd[0]), 64'd0);
        end
        drive(1'b0, WRITE, '0, '0);
        tick();

        // Back-to-back directed vectors observed on the READ_LAT=1 instance.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].rw, tbl[i].addr, tbl[i].wdata);
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(rv[0]), 64'(tbl[i].exp_valid));
            if (tbl[i].rw == READ) chk($sformatf("tbl%0d_data", i), 64'(rd[0]), 64'(tbl[i].exp_data));
        end
        drive(1'b0, WRITE, '0, '0);
        for (int i = 0; i < 4; i++) tick();

        // Response latency per instance for a single read of addr 3.
        for (int l = 0; l < NI; l++) first[l] = 0;
        drive(1'b1, READ, 4'd3, '0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            drive(1'b0, WRITE, '0, '0);
            for (int l = 0; l < NI; l++) if (rv[l] && first[l] == 0) first[l] = c;
        end
        for (int l = 0; l < NI; l++) begin
            chk($sformatf("latency_lat%0d", lats[l]), 64'(first[l]), 64'(lats[l]));
            chk($sformatf("latency_data_lat%0d", lats[l]), 64'(rd[l]), 64'hA5);
        end

        // Reset two cycles after a READ_LAT=4 read: the response must be dropped.
        drive(1'b1, READ, 4'd3, '0);
        tick();
        drive(1'b0, WRITE, '0, '0);
        tick();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("drop_valid_c%0d", c), 64'(rv[2]), 64'd0);
            chk($sformatf("drop_data_c%0d", c), 64'(rd[2]), 64'd0);
        end
        n = 6;
        while (!idn[0] && n < 200) begin
            tick();
            n++;
        end
        chk("init_cycles_after_drop", 64'(n), 64'(DEPTH));
        drive(1'b1, READ, 4'd3, '0);
        tick();
        drive(1'b0, WRITE, '0, '0);
        chk("cleared_valid", 64'(rv[0]), 64'd1);
        chk("cleared_data", 64'(rd[0]), 64'd0);

        // Write held pending through the sweep is taken on the first ready edge.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        drive(1'b1, WRITE, 4'd0, 8'hFF);
        n = 0;
        while (!rdy[0] && n < 200) begin
            tick();
            n++;
        end
        chk("held_req_wait", 64'(n), 64'(DEPTH));
        tick();
        drive(1'b1, READ, 4'd0, '0);
        tick();
        drive(1'b0, WRITE, '0, '0);
        chk("held_req_valid", 64'(rv[0]), 64'd1);
        chk("held_req_data", 64'(rd[0]), 64'hFF);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            RST = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            tick();
        end
        RST = 1'b0;
        drive(1'b0, WRITE, '0, '0);
        for (int c = 0; c < 24; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
Parametrised successor to the 8-bit single-request memory. It is a DATA_W x 2^ADDR_W synchronous RAM with a valid/ready request channel, a pipelined read response with configurable latency, and back-to-back requests (one per cycle). After every reset it sweeps the array to zero. It sits between the CPU bus sequencer and the system bus.

Parameters:
DATA_W, 8, data word width in bits (1..64)
ADDR_W, 8, address width; depth = 2**ADDR_W
READ_LAT, 1, cycles from read acceptance to rsp_valid (1..4)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block accepts request this cycle
req_rw  in  1  1 = READ, 0 = WRITE
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  rsp_rdata valid this cycle, one-cycle pulse per read
rsp_rdata  out  DATA_W  read data
init_done  out  1  clear sweep finished

Behaviour:
- One clock; reset is synchronous and active-high. RST sampled high at a CLK edge:
  - state <= ST_INIT, clear pointer <= 0.
  - All read-pipeline valids <= 0, so in-flight reads are dropped with no response.
  - Outputs during and after reset: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- FSM states ST_INIT and ST_READY:
  - ST_INIT: each cycle writes 0 to mem[ptr] and increments ptr. When ptr == 2**ADDR_W-1 is written, go to ST_READY and set init_done=1.
  - The sweep takes exactly 2**ADDR_W cycles after reset release. The pointer must not wrap back to 0.
  - ST_READY: req_ready=1 permanently. Only RST leaves this state.
- Handshake: a request is accepted on an edge where req_valid && req_ready. req_valid while req_ready=0 is ignored; the requester holds it.
- Write (req_rw=0): mem[req_addr] <= req_wdata at the accepting edge. No response is produced.
- Read (req_rw=1): data is captured at the accepting edge and travels through a READ_LAT-stage valid/data pipeline.
  - rsp_valid is high in the single cycle after the READ_LAT-th edge from acceptance (READ_LAT=1: the cycle right after acceptance).
  - No response backpressure. The consumer must take rsp_rdata when rsp_valid=1.
- Back-to-back: one request per cycle, sustained. Responses come out in request order. N consecutive reads give N consecutive rsp_valid pulses.
- Write followed by a read of the same address on the next cycle returns the new data.
- rsp_rdata holds its last value when rsp_valid=0. It is not cleared between reads, only by RST.
- Address is a plain ADDR_W index; no out-of-range case exists.
- READ_LAT outside 1..4 is a compile-time error via an elaboration check.

Optional Feature:
MEM_BUS_OUT_EN
- With the macro: adds port uniBus, inout, DATA_W.
  - Driven with rsp_rdata exactly in cycles where rsp_valid=1, otherwise all bits Z.
  - uniBus is output-only from this block; write data still comes from req_wdata.
  - Keeps compatibility with the shared system bus.
- Without the macro: no uniBus port and no tri-state logic anywhere in the block.

Decomposition:
- Package mem_pkg:
  - state enum mem_state_e {ST_INIT, ST_READY}.
  - constants READ=1'b1, WRITE=1'b0.
  - constant MAX_READ_LAT=4.
- One sub-module, mem_read_pipe: parametrised (DATA_W, READ_LAT) valid+data shift pipeline with synchronous reset of the valid bits only.
- param_memory instantiates one mem_read_pipe and holds the array and FSM.

Test Plan:
1. Reset/init: DATA_W=8, ADDR_W=4. Pulse RST for 2 cycles -> req_ready=0, init_done=0 for exactly 16 cycles after release. Then init_done=1, and reads of addr 0..15 all return 8'h00.
2. Write/read: write 8'hA5 to addr 3, then read addr 3 on the next cycle. READ_LAT=1 -> rsp_valid one cycle after read acceptance, rsp_rdata=8'hA5. Repeat with READ_LAT=3 -> pulse 3 cycles after acceptance.
3. Back-to-back reads: preload 0x10,0x20,0x30 at addr 0,1,2, issue 3 consecutive reads -> 3 consecutive rsp_valid cycles with data 0x10,0x20,0x30, in order.
4. Reset mid-operation: READ_LAT=4, issue read, assert RST 2 cycles later -> rsp_valid never rises, rsp_rdata=0, init sweep restarts and old data reads back as 0.
5. Requests during init: hold req_valid=1 (write 8'hFF, addr 0) from reset release -> not accepted until req_ready=1, accepted on the first ready edge, then a read of addr 0 returns 8'hFF.
6. MEM_BUS_OUT_EN defined: uniBus equals rsp_rdata when rsp_valid=1, and is 'z on all bits in every other cycle, including during RST and ST_INIT.
